// File: rtl/dff_stream_checker_if.sv
// dff_chk_if: observed D/Q stream, controls and checker results grouped for dff_stream_checker
interface dff_chk_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d_obs;
  logic [WIDTH-1:0] q_obs;
  logic             mismatch;
  logic             fail;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] chg_cnt;
  logic [CNT_W-1:0] max_hold;
  logic [1:0]       state;
  modport master (
    output en, clr, d_obs, q_obs,
    input  mismatch, fail, err_cnt, chg_cnt, max_hold, state
  );
  modport slave (
    input  en, clr, d_obs, q_obs,
    output mismatch, fail, err_cnt, chg_cnt, max_hold, state
  );
endinterface

// File: rtl/dff_stream_checker.sv
// dff_stream_checker: checks q_obs == d_obs delayed one clock; DFF_CHK_STOP_ON_FAIL_EN halts on first mismatch
module dff_stream_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic      clk,
  input logic      rst,
  dff_chk_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CHECK, HALT} state_t;
  localparam logic [CNT_W-1:0] SAT = '1;
  state_t           st, st_nxt;
  logic [WIDTH-1:0] exp_q, q_prev, d_prev;
  logic [CNT_W-1:0] hold_cnt, hold_nxt, err_cnt, chg_cnt, max_hold;
  logic             mismatch, fail, active, miss, chg;
  always_comb begin
    active   = st == CHECK && bus.en && !bus.clr;
    miss     = active && bus.q_obs != exp_q;
    chg      = active && bus.q_obs != q_prev;
    hold_nxt = bus.d_obs != d_prev ? CNT_W'(1) : hold_cnt == SAT ? SAT : hold_cnt + CNT_W'(1);
    st_nxt   = bus.clr ? (st == HALT ? IDLE : st) : st == HALT ? HALT : bus.en ? CHECK : IDLE;
`ifdef DFF_CHK_STOP_ON_FAIL_EN
    st_nxt   = miss ? HALT : st_nxt;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      exp_q    <= '0;
      q_prev   <= '0;
      d_prev   <= '0;
      hold_cnt <= '0;
      err_cnt  <= '0;
      chg_cnt  <= '0;
      max_hold <= '0;
      mismatch <= 1'b0;
      fail     <= 1'b0;
    end else begin
      st       <= st_nxt;
      exp_q    <= bus.d_obs;
      q_prev   <= bus.q_obs;
      d_prev   <= bus.d_obs;
      mismatch <= miss;
      if (bus.clr) begin
        hold_cnt <= '0;
        err_cnt  <= '0;
        chg_cnt  <= '0;
        max_hold <= '0;
        fail     <= 1'b0;
      end else if (active) begin
        hold_cnt <= hold_nxt;
        max_hold <= hold_nxt > max_hold ? hold_nxt : max_hold;
        err_cnt  <= miss && err_cnt != SAT ? err_cnt + CNT_W'(1) : err_cnt;
        chg_cnt  <= chg && chg_cnt != SAT ? chg_cnt + CNT_W'(1) : chg_cnt;
        fail     <= fail | miss;
      end
    end
  end
  assign bus.mismatch = mismatch;
  assign bus.fail     = fail;
  assign bus.err_cnt  = err_cnt;
  assign bus.chg_cnt  = chg_cnt;
  assign bus.max_hold = max_hold;
  assign bus.state    = st;
endmodule

// File: tb/tb_dff_stream_checker.sv
// tb_dff_stream_checker: directed vectors against dff_stream_checker watching a bench-modelled flip-flop
module tb_dff_stream_checker;
`ifdef DFF_CHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frc = 1'b0;
  logic [3:0] frc_val = 4'd0;
  logic [3:0] ff_q;
  int         errors = 0;
  int         checks = 0;
  dff_chk_if #(.WIDTH(4), .CNT_W(8)) bus ();
  dff_stream_checker #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_ff @(posedge clk or posedge rst) ff_q <= rst ? 4'd0 : bus.d_obs;
  assign bus.q_obs = frc ? frc_val : ff_q;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic resync();
    bus.en = 1'b0;
    tick(1);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    bus.en = 1'b1;
    tick(1);
  endtask
  int vals[20] = '{1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 6};
  int hl[20]   = '{3, 1, 7, 0, 2, 5, 1, 4, 0, 6, 2, 3, 1, 2, 7, 0, 3, 2, 5, 1};
  initial begin
    bus.en = 1'b0;
    bus.clr = 1'b0;
    bus.d_obs = 4'd0;
    tick(3);
    chk("rst_state", bus.state, 0);
    chk("rst_err", bus.err_cnt, 0);
    chk("rst_chg", bus.chg_cnt, 0);
    chk("rst_hold", bus.max_hold, 0);
    chk("rst_fail", bus.fail, 0);
    chk("rst_mm", bus.mismatch, 0);
    rst = 1'b0;
    bus.en = 1'b1;
    bus.d_obs = 4'd5;
    tick(1);
    chk("enter_check", bus.state, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("clean_mm", bus.mismatch, 0);
    end
    chk("clean_err", bus.err_cnt, 0);
    chk("clean_chg", bus.chg_cnt, 1);
    chk("clean_hold", bus.max_hold, 10);
    frc = 1'b1;
    frc_val = 4'd3;
    tick(1);
    frc = 1'b0;
    chk("force_mm", bus.mismatch, 1);
    chk("force_err", bus.err_cnt, 1);
    chk("force_fail", bus.fail, 1);
    chk("force_state", bus.state, STOP ? 2 : 1);
    tick(1);
    chk("pulse_end", bus.mismatch, 0);
    chk("fail_sticky", bus.fail, 1);
    chk("chg_both", bus.chg_cnt, STOP ? 2 : 3);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    chk("clr_err", bus.err_cnt, 0);
    chk("clr_fail", bus.fail, 0);
    chk("clr_hold", bus.max_hold, 0);
    chk("clr_state", bus.state, STOP ? 0 : 1);
    resync();
    for (int i = 0; i < 20; i++)
      for (int j = 0; j < hl[i]; j++) begin
        bus.d_obs = 4'(vals[i]);
        tick(1);
      end
    tick(1);
    chk("seq_err", bus.err_cnt, 0);
    chk("seq_hold", bus.max_hold, 7);
    chk("seq_chg", bus.chg_cnt, 17);
    bus.en = 1'b0;
    frc = 1'b1;
    frc_val = 4'd9;
    tick(5);
    chk("dis_err", bus.err_cnt, 0);
    chk("dis_state", bus.state, 0);
    chk("dis_mm", bus.mismatch, 0);
    frc = 1'b0;
    bus.en = 1'b1;
    tick(1);
    chk("reenable", bus.state, 1);
    frc = 1'b1;
    tick(258);
    chk("sat_err", bus.err_cnt, STOP ? 1 : 255);
    chk("sat_hold", bus.max_hold, STOP ? 7 : 255);
    chk("sat_chg", bus.chg_cnt, 18);
    chk("sat_fail", bus.fail, 1);
    chk("sat_mm", bus.mismatch, STOP ? 0 : 1);
    chk("sat_state", bus.state, STOP ? 2 : 1);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    chk("sat_clr_err", bus.err_cnt, 0);
    chk("sat_clr_chg", bus.chg_cnt, 0);
    chk("sat_clr_fail", bus.fail, 0);
    chk("sat_clr_mm", bus.mismatch, 0);
    chk("sat_clr_state", bus.state, STOP ? 0 : 1);
    frc = 1'b0;
    resync();
    frc = 1'b1;
    tick(2);
    frc = 1'b0;
    chk("two_err", bus.err_cnt, STOP ? 1 : 2);
    chk("two_state", bus.state, STOP ? 2 : 1);
    chk("two_mm", bus.mismatch, STOP ? 0 : 1);
    bus.en = 1'b0;
    tick(1);
    chk("halt_en_ignored", bus.state, STOP ? 2 : 0);
    chk("halt_fail", bus.fail, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_state", bus.state, 0);
    chk("async_fail", bus.fail, 0);
    chk("async_err", bus.err_cnt, 0);
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dff_stream_checker.md
Name: dff_stream_checker

Overview:
- Self-checking monitor for the registered data path: observes the D input and Q output of a WIDTH-bit D flip-flop stage and checks that Q equals D delayed by exactly one clock.
- Sits alongside the flip-flop, on the receiving end of the stimulus stream, and is instantiated in benches or in silicon debug wrappers.
- Reports per-cycle mismatches, error and Q-change counts, longest D hold time, and a sticky fail flag.

Parameters:
- WIDTH, 4, data width of observed D/Q.
- CNT_W, 8, width of err_cnt, chg_cnt, max_hold; all counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  clock, same clock as the observed flip-flop.
- rst  input  1  asynchronous active-high reset; same reset as the observed flip-flop.
- en  input  1  checking enable; when 0, no compare and no counting.
- clr  input  1  synchronous clear of counters, fail and hold tracking; takes priority over en.
- d_obs  input  WIDTH  observed flip-flop D input.
- q_obs  input  WIDTH  observed flip-flop Q output.
- mismatch  output  1  one-cycle pulse; a compare failed at the previous edge.
- fail  output  1  sticky; set by the first mismatch.
- err_cnt  output  CNT_W  number of mismatches.
- chg_cnt  output  CNT_W  number of edges where q_obs differed from its previously sampled value.
- max_hold  output  CNT_W  longest run of consecutive edges with d_obs unchanged.
- state  output  2  0 = IDLE, 1 = CHECK, 2 = HALT.

Behaviour:
- Reset (async, rst = 1):
  - exp_q = 0, q_prev = 0, d_prev = 0, hold_cnt = 0.
  - All outputs = 0; state = IDLE.
- Reference model: on every posedge, exp_q <= d_obs, independent of en.
- Compare: at each posedge in CHECK, compare q_obs against exp_q, both taken as their pre-edge values. Both hold D from the previous edge.
- Mismatch when q_obs != exp_q:
  - mismatch goes high for exactly the following cycle.
  - err_cnt increments by 1.
  - fail is set to 1.
  - Latency from the failing edge to mismatch = 1 cycle.
- First edge after reset release: exp_q = 0 and q_obs = 0, so a correct flip-flop passes.
- chg_cnt: increments in CHECK when q_obs != q_prev; q_prev <= q_obs on every edge.
- Hold tracking (CHECK only):
  - If d_obs == d_prev, hold_cnt increments (saturating); otherwise hold_cnt = 1.
  - max_hold <= max(max_hold, hold_cnt next value).
  - d_prev <= d_obs on every edge.
- State transitions:
  - IDLE -> CHECK when en = 1.
  - CHECK -> IDLE when en = 0.
  - HALT is entered only with the optional feature.
- clr = 1:
  - err_cnt, chg_cnt, max_hold, hold_cnt, fail and mismatch go to 0.
  - State goes to IDLE if HALT, otherwise is unchanged.
  - No compare that edge.
  - exp_q, q_prev and d_prev still update.
- Saturation: counters stop at all-ones with no wrap; fail remains 1.
- Simultaneous events:
  - Mismatch and Q-change on the same edge update both counters.
  - clr overrides en and mismatch.
- Reset mid-operation: asynchronous return to reset values, whatever the state.

Optional Feature:
- Macro: DFF_CHK_STOP_ON_FAIL_EN.
- Defined:
  - First mismatch moves CHECK -> HALT.
  - In HALT, all counters, fail and max_hold are frozen, mismatch stays 0, and en is ignored.
  - Only clr or rst leaves HALT.
- Not defined:
  - HALT is unreachable.
  - Checking continues after failures, and err_cnt accumulates.

Test Plan:
- Reset for 3 clocks, en = 1, d_obs = 4'd5 wired through a correct flip-flop for 10 cycles -> mismatch never 1, err_cnt = 0, chg_cnt = 1, max_hold = 10.
- Force q_obs = 4'd3 while exp_q = 4'd5 for one edge -> mismatch high for 1 cycle after that edge, err_cnt = 1, fail = 1 and remains 1.
- 20 random d_obs values, each held for 0-7 cycles, correct flip-flop -> err_cnt = 0, max_hold equals the longest applied hold (e.g. 7), chg_cnt equals the number of distinct consecutive values.
- en = 0 with 5 forced mismatches -> err_cnt = 0, state = IDLE; raise en -> state = 1 the next cycle.
- err_cnt driven to 255 plus 3 more mismatches -> err_cnt = 255; pulse clr -> all counters and fail = 0.
- With DFF_CHK_STOP_ON_FAIL_EN, 2 forced mismatches -> err_cnt = 1, state = 2, counters frozen; clr -> state = 0. Without the macro -> err_cnt = 2, state = 1.
